// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths, source tags and tag-pipe entry type for the fetch/data memory arbiter.
package mem_port_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int BE_W   = DATA_W / 8;

  typedef enum logic {
    MEM_SRC_IF = 1'b0,
    MEM_SRC_D  = 1'b1
  } mem_src_e;

  typedef struct packed {
    logic     valid;
    mem_src_e src;
  } mem_tag_t;

  function automatic mem_tag_t kill_if_tag(input mem_tag_t t, input logic flush);
    mem_tag_t r;
    r = t;
    if (flush && (t.src == MEM_SRC_IF)) r.valid = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/mem_tag_pipe.sv
// Shift register of {valid, src} tags that follows each read through the memory latency.
module mem_tag_pipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  mem_tag_t push_i,
  input  logic     flush_if_i,
  output mem_tag_t head_o
);

  mem_tag_t stage_q [DEPTH];
  mem_tag_t stage_d [DEPTH];

  // A flush kills fetch tags on entry, in flight and at the head in the same cycle.
  always_comb begin
    stage_d[0] = kill_if_tag(push_i, flush_if_i);
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = kill_if_tag(stage_q[i-1], flush_if_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign head_o = rst_i ? '0 : kill_if_tag(stage_q[DEPTH-1], flush_if_i);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and load/store,
// data first, with a starvation counter guaranteeing fetch progress.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LOAD_LATENCY = 1,
  parameter int MAX_IF_WAIT  = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_grant_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              if_flush_i,
  input  logic              d_req_i,
  input  logic [BE_W-1:0]   d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_grant_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [BE_W-1:0]   mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam logic [2:0] WAIT_MAX = 3'(MAX_IF_WAIT);

  logic [2:0] wait_q, wait_d;
  logic       if_win, d_win;
  mem_tag_t   push_tag, head_tag;

  // Grants are suppressed during reset so every output reads zero.
  always_comb begin
    if_win = 1'b0;
    d_win  = 1'b0;
    if (!rst_i) begin
      if (if_req_i && (!d_req_i || (wait_q >= WAIT_MAX))) begin
        if_win = 1'b1;
      end else if (d_req_i) begin
        d_win = 1'b1;
      end
    end
  end

  always_comb begin
    mem_addr_o = '0;
    mem_we_o   = '0;
    push_tag   = '0;
    if (if_win) begin
      mem_addr_o = if_addr_i;
      push_tag   = '{valid: 1'b1, src: MEM_SRC_IF};
    end else if (d_win) begin
      mem_addr_o = d_addr_i;
      mem_we_o   = d_we_i;
      push_tag   = '{valid: (d_we_i == '0), src: MEM_SRC_D};
    end
  end

  always_comb begin
    wait_d = '0;
    if (if_req_i && !if_win) begin
      wait_d = (wait_q >= WAIT_MAX) ? WAIT_MAX : wait_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  mem_tag_pipe #(
    .DEPTH (LOAD_LATENCY)
  ) u_tag_pipe (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (push_tag),
    .flush_if_i (if_flush_i),
    .head_o     (head_tag)
  );

  assign if_grant_o  = if_win;
  assign d_grant_o   = d_win;
  assign mem_wdata_o = rst_i ? '0 : d_wdata_i;
  assign if_rvalid_o = head_tag.valid && (head_tag.src == MEM_SRC_IF);
  assign d_rvalid_o  = head_tag.valid && (head_tag.src == MEM_SRC_D);
  assign if_rdata_o  = rst_i ? '0 : mem_rdata_i;
  assign d_rdata_o   = rst_i ? '0 : mem_rdata_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random and directed bench for mem_port_arbiter against a cycle-indexed
// reference model of grants, return schedule and memory contents.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int LL       = 2;
  localparam int MAXW     = 3;
  localparam int HORIZON  = 4096;

  logic              clk = 1'b0;
  logic              rst;
  logic              ifReq, dReq, ifFlush;
  logic [ADDR_W-1:0] ifAddr, dAddr;
  logic [BE_W-1:0]   dWe;
  logic [DATA_W-1:0] dWdata;
  logic              if_grant, if_rvalid, d_grant, d_rvalid;
  logic [DATA_W-1:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [BE_W-1:0]   mem_we;

  int totalChecks = 0;
  int badChecks   = 0;

  mem_port_arbiter #(
    .LOAD_LATENCY (LL),
    .MAX_IF_WAIT  (MAXW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .if_req_i    (ifReq),
    .if_addr_i   (ifAddr),
    .if_grant_o  (if_grant),
    .if_rvalid_o (if_rvalid),
    .if_rdata_o  (if_rdata),
    .if_flush_i  (ifFlush),
    .d_req_i     (dReq),
    .d_we_i      (dWe),
    .d_addr_i    (dAddr),
    .d_wdata_i   (dWdata),
    .d_grant_o   (d_grant),
    .d_rvalid_o  (d_rvalid),
    .d_rdata_o   (d_rdata),
    .mem_addr_o  (mem_addr),
    .mem_we_o    (mem_we),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] initWord(input int i);
    return 64'h0123_4567_89AB_CDEF ^ (64'(i) * 64'h9E37_79B9_7F4A_7C15);
  endfunction

  // Behavioural BRAM: byte-enabled writes, reads delivered LL cycles later.
  logic [63:0] memArr [16];
  logic [63:0] rdPipe [LL];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) memArr[i] <= initWord(i);
    end else begin
      for (int b = 0; b < BE_W; b++)
        if (mem_we[b]) memArr[mem_addr[6:3]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    rdPipe[0] <= memArr[mem_addr[6:3]];
    for (int k = 1; k < LL; k++) rdPipe[k] <= rdPipe[k-1];
  end
  assign mem_rdata = rdPipe[LL-1];

  // Reference model: expected returns scheduled by absolute cycle number.
  int          cyc = 0;
  int          waitM = 0;
  bit          lastIfG, lastDG;
  bit          ifRetV [HORIZON];
  bit          dRetV  [HORIZON];
  logic [63:0] ifRetData [HORIZON];
  logic [63:0] dRetData  [HORIZON];
  logic [63:0] refMem [16];

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s cycle=%0d got=%h want=%h", tag, cyc, observed, expected);
    end
  endtask

  task automatic resetModel();
    waitM = 0;
    for (int c = 0; c < HORIZON; c++) begin
      ifRetV[c] = 1'b0;
      dRetV[c]  = 1'b0;
    end
    for (int i = 0; i < 16; i++) refMem[i] = initWord(i);
  endtask

  task automatic checkCycle();
    bit          expIfG, expDG, expIfV;
    logic [63:0] expAddr, expWe;
    expIfG  = ifReq && (!dReq || waitM >= MAXW);
    expDG   = dReq && !expIfG;
    expAddr = expIfG ? 64'(ifAddr) : (expDG ? 64'(dAddr) : 64'd0);
    expWe   = expDG ? 64'(dWe) : 64'd0;
    expIfV  = ifRetV[cyc] && !ifFlush;
    checkOutput("ifGrant", 64'(if_grant), 64'(expIfG));
    checkOutput("dGrant", 64'(d_grant), 64'(expDG));
    checkOutput("memAddr", 64'(mem_addr), expAddr);
    checkOutput("memWe", 64'(mem_we), expWe);
    checkOutput("memWdata", mem_wdata, dWdata);
    checkOutput("ifRvalid", 64'(if_rvalid), 64'(expIfV));
    checkOutput("dRvalid", 64'(d_rvalid), 64'(dRetV[cyc]));
    if (expIfV) checkOutput("ifRdata", if_rdata, ifRetData[cyc]);
    if (dRetV[cyc]) checkOutput("dRdata", d_rdata, dRetData[cyc]);
    if (expIfG) begin
      ifRetV[cyc+LL]    = 1'b1;
      ifRetData[cyc+LL] = refMem[ifAddr[6:3]];
    end
    if (ifFlush)
      for (int c = cyc; c <= cyc + LL; c++) ifRetV[c] = 1'b0;
    if (expDG && dWe == '0) begin
      dRetV[cyc+LL]    = 1'b1;
      dRetData[cyc+LL] = refMem[dAddr[6:3]];
    end else if (expDG) begin
      for (int b = 0; b < BE_W; b++)
        if (dWe[b]) refMem[dAddr[6:3]][8*b +: 8] = dWdata[8*b +: 8];
    end
    if (ifReq && !expIfG) waitM = (waitM >= MAXW) ? MAXW : waitM + 1;
    else waitM = 0;
    lastIfG = expIfG;
    lastDG  = expDG;
  endtask

  task automatic stepCycle();
    @(negedge clk);
    checkCycle();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    #2;
    checkOutput("rstIfGrant", 64'(if_grant), 64'd0);
    checkOutput("rstDGrant", 64'(d_grant), 64'd0);
    checkOutput("rstIfRvalid", 64'(if_rvalid), 64'd0);
    checkOutput("rstDRvalid", 64'(d_rvalid), 64'd0);
    checkOutput("rstIfRdata", if_rdata, 64'd0);
    checkOutput("rstDRdata", d_rdata, 64'd0);
    checkOutput("rstMemAddr", 64'(mem_addr), 64'd0);
    checkOutput("rstMemWe", 64'(mem_we), 64'd0);
    checkOutput("rstMemWdata", mem_wdata, 64'd0);
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    rst = 1'b0;
    resetModel();
  endtask

  task automatic applyStimulus();
    if (!(ifReq && !lastIfG)) begin
      ifReq  = ($urandom_range(0, 9) < 6);
      ifAddr = ADDR_W'({$urandom_range(0, 15), 3'b000});
    end
    if (!(dReq && !lastDG)) begin
      dReq   = ($urandom_range(0, 9) < 6);
      dAddr  = ADDR_W'({$urandom_range(0, 15), 3'b000});
      dWe    = ($urandom_range(0, 9) < 6) ? 8'h00 : 8'($urandom_range(1, 255));
      dWdata = {$urandom, $urandom};
    end
    ifFlush = ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    rst = 1'b1;
    ifReq = 1'b1; dReq = 1'b1; ifFlush = 1'b0;
    ifAddr = 32'h30; dAddr = 32'h50; dWe = 8'hFF; dWdata = 64'hFFFF_FFFF_FFFF_FFFF;
    lastIfG = 1'b0; lastDG = 1'b0;
    @(posedge clk);
    #1;
    doReset();

    // Idle
    ifReq = 1'b0; dReq = 1'b0; dWe = 8'h00;
    repeat (3) stepCycle();

    // Fetch only
    ifReq = 1'b1; ifAddr = 32'h10;
    stepCycle();
    ifReq = 1'b0;
    repeat (3) stepCycle();

    // Contention: D,D,D,IF repeating
    ifReq = 1'b1; ifAddr = 32'h20; dReq = 1'b1; dWe = 8'h00; dAddr = 32'h40;
    repeat (9) stepCycle();
    ifReq = 1'b0; dReq = 1'b0;
    repeat (3) stepCycle();

    // Store then load to the same address
    dReq = 1'b1; dWe = 8'hFF; dWdata = 64'hDEADBEEF_CAFEF00D; dAddr = 32'h80;
    stepCycle();
    dWe = 8'h00;
    stepCycle();
    dReq = 1'b0;
    repeat (3) stepCycle();

    // Flush with an interleaved load
    ifReq = 1'b1; ifAddr = 32'h08;
    stepCycle();
    dReq = 1'b1; dAddr = 32'h18; ifAddr = 32'h28;
    stepCycle();
    dReq = 1'b0; ifFlush = 1'b1; ifAddr = 32'h38;
    stepCycle();
    ifFlush = 1'b0; ifReq = 1'b0;
    repeat (4) stepCycle();

    // Reset while a load is in flight
    dReq = 1'b1; dAddr = 32'h48; dWe = 8'h00; dWdata = 64'h1234_5678_9ABC_DEF0;
    stepCycle();
    doReset();
    dReq = 1'b0;
    repeat (4) stepCycle();

    // Random traffic with requester hold behaviour
    lastIfG = 1'b1; lastDG = 1'b1;
    repeat (400) begin
      applyStimulus();
      stepCycle();
    end
    ifReq = 1'b0; dReq = 1'b0; ifFlush = 1'b0;
    repeat (LL + 2) stepCycle();

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
